// File: rtl/uart_receiver.sv
// UART receive engine: 16x oversampled, runtime-configurable frame format
// (5-9 data bits, optional parity, 1/2 stop bits, six baud rates).
module uart_receiver #(
    parameter int unsigned SYS_CLOCK  = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       UART_RX,
    input  logic [2:0] UART_Baud_Rate_Mode_In,
    input  logic [2:0] UART_Num_Data_Bits_In,
    input  logic       UART_Parity_Enable_In,
    input  logic       UART_Even_Oddb_Parity_In,
    input  logic       UART_Num_Stop_Bits_In,
    output logic [8:0] Data_Out,
    output logic       Data_Valid_Out,
    output logic       Parity_Error_Out,
    output logic       Framing_Error_Out,
    output logic       RX_Busy_Out
);

    localparam int unsigned DIV_4800   = (SYS_CLOCK + 8 * 4800)   / (16 * 4800);
    localparam int unsigned DIV_9600   = (SYS_CLOCK + 8 * 9600)   / (16 * 9600);
    localparam int unsigned DIV_19200  = (SYS_CLOCK + 8 * 19200)  / (16 * 19200);
    localparam int unsigned DIV_38400  = (SYS_CLOCK + 8 * 38400)  / (16 * 38400);
    localparam int unsigned DIV_57600  = (SYS_CLOCK + 8 * 57600)  / (16 * 57600);
    localparam int unsigned DIV_115200 = (SYS_CLOCK + 8 * 115200) / (16 * 115200);
    localparam logic [3:0]  MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  LAST_TICK  = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    function automatic logic [15:0] div_for(input logic [2:0] mode);
        case (mode)
            3'd0:    return 16'(DIV_4800);
            3'd1:    return 16'(DIV_9600);
            3'd2:    return 16'(DIV_19200);
            3'd3:    return 16'(DIV_38400);
            3'd4:    return 16'(DIV_57600);
            default: return 16'(DIV_115200);
        endcase
    endfunction

    state_t      state;
    logic        rx_meta, rx_sync;
    logic [1:0]  settle;
    logic        armed;
    logic [15:0] div_sel, div_cnt;
    logic [3:0]  tick_cnt;
    logic [3:0]  bit_idx, last_idx;
    logic        par_en, par_even, two_stop;
    logic [8:0]  shift;
    logic        par_acc, ferr_acc;
    logic        tick, mid, done, sync_ok;

    // settle keeps the reset value of the synchroniser from arming the receiver
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            settle  <= '0;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
            if (settle != 2'd2) settle <= settle + 2'd1;
        end
    end

    always_comb begin
        sync_ok = (settle == 2'd2);
        tick    = (div_cnt == div_sel - 16'd1);
        mid     = tick && (tick_cnt == MID_TICK);
        done    = mid && ((state == STOP1 && !two_stop) || state == STOP2);
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state             <= IDLE;
            armed             <= 1'b0;
            div_sel           <= '0;
            div_cnt           <= '0;
            tick_cnt          <= '0;
            bit_idx           <= '0;
            last_idx          <= '0;
            par_en            <= 1'b0;
            par_even          <= 1'b0;
            two_stop          <= 1'b0;
            shift             <= '0;
            par_acc           <= 1'b0;
            ferr_acc          <= 1'b0;
            Data_Out          <= '0;
            Data_Valid_Out    <= 1'b0;
            Parity_Error_Out  <= 1'b0;
            Framing_Error_Out <= 1'b0;
            RX_Busy_Out       <= 1'b0;
        end else begin
            Data_Valid_Out <= 1'b0;
            if (state != IDLE) begin
                if (tick) begin
                    div_cnt  <= '0;
                    tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 4'd1;
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
            case (state)
                IDLE: begin
                    // armed only after the line has been seen high while idle
                    if (sync_ok && rx_sync) armed <= 1'b1;
                    if (armed && !rx_sync) begin
                        state       <= START;
                        armed       <= 1'b0;
                        RX_Busy_Out <= 1'b1;
                        div_sel     <= div_for(UART_Baud_Rate_Mode_In);
                        div_cnt     <= '0;
                        tick_cnt    <= '0;
                        last_idx    <= (UART_Num_Data_Bits_In >= 3'd4) ? 4'd8
                                       : {1'b0, UART_Num_Data_Bits_In} + 4'd4;
                        par_en      <= UART_Parity_Enable_In;
                        par_even    <= UART_Even_Oddb_Parity_In;
                        two_stop    <= UART_Num_Stop_Bits_In;
                        shift       <= '0;
                        par_acc     <= 1'b0;
                        ferr_acc    <= 1'b0;
                    end
                end
                START: begin
                    if (mid) begin
                        if (!rx_sync) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state       <= IDLE;
                            RX_Busy_Out <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift[bit_idx] <= rx_sync;
                        par_acc        <= par_acc ^ rx_sync;
                        bit_idx        <= bit_idx + 4'd1;
                        if (bit_idx == last_idx) state <= par_en ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (mid) begin
                        par_acc <= par_acc ^ rx_sync;
                        state   <= STOP1;
                    end
                end
                STOP1: begin
                    if (mid && two_stop) begin
                        ferr_acc <= !rx_sync;
                        state    <= STOP2;
                    end
                end
                default: ;
            endcase
            if (done) begin
                state             <= IDLE;
                RX_Busy_Out       <= 1'b0;
                Data_Valid_Out    <= 1'b1;
                Data_Out          <= shift;
                Parity_Error_Out  <= par_en && (par_acc ^ !par_even);
                Framing_Error_Out <= ferr_acc || !rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Table-driven bench for uart_receiver with hand-written sequences for
// false start, back-to-back frames and reset with the line held low.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [2:0] mode, nbits;
    logic       par_en, even, stop2;
    logic [8:0] data_out;
    logic       valid, perr, ferr, busy;

    // SYS_CLOCK lowered so the slow baud rates stay within a short run
    uart_receiver #(.SYS_CLOCK(10_000_000), .OVERSAMPLE(16)) dut (
        .Clk_In                  (clk),
        .Reset_In                (rst_n),
        .UART_RX                 (rx),
        .UART_Baud_Rate_Mode_In  (mode),
        .UART_Num_Data_Bits_In   (nbits),
        .UART_Parity_Enable_In   (par_en),
        .UART_Even_Oddb_Parity_In(even),
        .UART_Num_Stop_Bits_In   (stop2),
        .Data_Out                (data_out),
        .Data_Valid_Out          (valid),
        .Parity_Error_Out        (perr),
        .Framing_Error_Out       (ferr),
        .RX_Busy_Out             (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] mode;
        logic [2:0] nb;
        logic       pe;
        logic       ev;
        logic       s2;
        logic [8:0] data;
        logic       flip;
        logic       s2low;
        int         div;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [8:0]  d;
        logic        pe;
        logic        fe;
        int unsigned t;
    } cap_t;

    vec_t        vecs[8];
    cap_t        caps[$];
    int unsigned starts[$];
    logic        busy_seen = 1'b0;
    int          total = 0;
    int          bad = 0;

    always @(negedge clk) begin
        if (valid) caps.push_back('{data_out, perr, ferr, cyc});
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int i);
        mode   = vecs[i].mode;
        nbits  = vecs[i].nb;
        par_en = vecs[i].pe;
        even   = vecs[i].ev;
        stop2  = vecs[i].s2;
    endtask

    function automatic int num_bits(input logic [2:0] nb);
        return (nb >= 3'd4) ? 9 : int'(nb) + 5;
    endfunction

    task automatic send(input int i);
        logic bits[13];
        int   n, nb, bt;
        logic p;
        nb = num_bits(vecs[i].nb);
        bt = 16 * vecs[i].div;
        n = 0;
        bits[n++] = 1'b0;
        p = 1'b0;
        for (int k = 0; k < nb; k++) begin
            bits[n++] = vecs[i].data[k];
            p ^= vecs[i].data[k];
        end
        if (vecs[i].pe) bits[n++] = (vecs[i].ev ? p : ~p) ^ vecs[i].flip;
        bits[n++] = 1'b1;
        if (vecs[i].s2) bits[n++] = ~vecs[i].s2low;
        starts.push_back(cyc);
        rx = bits[0];
        wait_clks(8);
        // scramble the configuration inputs mid-frame; the receiver must ignore them
        mode = ~mode; nbits = ~nbits; par_en = ~par_en; even = ~even; stop2 = ~stop2;
        wait_clks(bt - 8);
        for (int k = 1; k < n; k++) begin
            rx = bits[k];
            wait_clks(bt);
        end
        rx = 1'b1;
        set_cfg(i);
    endtask

    task automatic check_frame(input int i);
        cap_t        c;
        int unsigned st, lat, base;
        int          m;
        st = starts.pop_front();
        total++;
        if (caps.size() == 0) begin
            bad++;
            $display("FAIL v%0d_valid: got no pulse expected one", i);
            return;
        end
        c = caps.pop_front();
        m = num_bits(vecs[i].nb) + int'(vecs[i].pe) + 1 + int'(vecs[i].s2);
        base = (8 + 16 * m) * vecs[i].div;
        lat = c.t - st;
        check($sformatf("v%0d_data", i), 32'(c.d), 32'(vecs[i].exp_data));
        check($sformatf("v%0d_perr", i), 32'(c.pe), 32'(vecs[i].exp_perr));
        check($sformatf("v%0d_ferr", i), 32'(c.fe), 32'(vecs[i].exp_ferr));
        check($sformatf("v%0d_latency_in_window(lat=%0d base=%0d)", i, lat, base),
              32'(lat >= base && lat <= base + 4), 32'd1);
    endtask

    task automatic glitch();
        wait_clks(200);
        set_cfg(4);
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_clks(44);
        rx = 1'b1;
        wait_clks(3 * 176);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_idle", 32'(busy), 32'd0);
        check("glitch_no_valid", caps.size(), 32'd0);
        check("glitch_data_held", 32'(data_out), 32'h015);
        check("glitch_ferr_held", 32'(ferr), 32'd1);
    endtask

    task automatic reset_mid();
        set_cfg(7);
        wait_clks(64);
        rx = 1'b0;
        wait_clks(528 + 100);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rstmid_data", 32'(data_out), 32'h000);
        check("rstmid_valid", 32'(valid), 32'd0);
        check("rstmid_perr", 32'(perr), 32'd0);
        check("rstmid_ferr", 32'(ferr), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3 * 528);
        check("rstlow_busy", 32'(busy), 32'd0);
        check("rstlow_no_frame", caps.size(), 32'd0);
        rx = 1'b1;
        wait_clks(528);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0,   5, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{3'd1, 3'd4, 1'b1, 1'b1, 1'b0, 9'h1B3, 1'b0, 1'b0,  65, 9'h1B3, 1'b0, 1'b0};
        vecs[2] = '{3'd1, 3'd4, 1'b1, 1'b1, 1'b0, 9'h1B3, 1'b1, 1'b0,  65, 9'h1B3, 1'b1, 1'b0};
        vecs[3] = '{3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 9'h015, 1'b0, 1'b1, 130, 9'h015, 1'b0, 1'b1};
        vecs[4] = '{3'd4, 3'd3, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b0,  11, 9'h03C, 1'b0, 1'b0};
        vecs[5] = '{3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0,  16, 9'h0FF, 1'b0, 1'b0};
        vecs[6] = '{3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0,  16, 9'h000, 1'b0, 1'b0};
        vecs[7] = '{3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0,  33, 9'h05A, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        set_cfg(0);
        wait_clks(3);
        check("reset_data", 32'(data_out), 32'h000);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_perr", 32'(perr), 32'd0);
        check("reset_ferr", 32'(ferr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(10);

        begin
            int i;
            i = 0;
            while (i < 8) begin
                if (i == 4) glitch();
                if (i == 7) reset_mid();
                set_cfg(i);
                wait_clks(32 * vecs[i].div);
                if (i == 5) begin
                    send(5);
                    send(6);
                    check_frame(5);
                    check_frame(6);
                    i = 7;
                end else begin
                    send(i);
                    check_frame(i);
                    i++;
                end
                check($sformatf("after_v%0d_extra_pulses", i - 1), caps.size(), 32'd0);
                check($sformatf("after_v%0d_busy", i - 1), 32'(busy), 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Standalone UART receive engine: deserialises one asynchronous serial line into parallel data words.
- Frame format is runtime-configurable: 5–9 data bits, optional even/odd parity, 1 or 2 stop bits, six baud rates (same mode encoding as the UART transmit path).
- Sits behind the device RX pin and feeds a host register/FIFO via a one-cycle valid pulse with error flags.

Parameters:
- SYS_CLOCK, 100_000_000, system clock frequency in Hz; used to derive baud divisors.
- OVERSAMPLE, 16, RX sample ticks per bit; fixed at 16, mid-bit sample at tick 7.

Ports:
- Clk_In  input  1  system clock; all logic on rising edge.
- Reset_In  input  1  asynchronous, active-low reset.
- UART_RX  input  1  serial line; idle high; asynchronous to Clk_In.
- UART_Baud_Rate_Mode_In  input  3  000=4800, 001=9600, 010=19200, 011=38400, 100=57600, 101=115200; 110/111 behave as 101.
- UART_Num_Data_Bits_In  input  3  000=5, 001=6, 010=7, 011=8, 100=9 bits; 101–111 behave as 100.
- UART_Parity_Enable_In  input  1  1 = parity bit follows data.
- UART_Even_Oddb_Parity_In  input  1  1 = even parity, 0 = odd parity.
- UART_Num_Stop_Bits_In  input  1  0 = one stop bit, 1 = two stop bits.
- Data_Out  output  9  received word, LSB-aligned, unused upper bits zero.
- Data_Valid_Out  output  1  one-cycle pulse when Data_Out and the error flags update.
- Parity_Error_Out  output  1  parity mismatch on the last frame.
- Framing_Error_Out  output  1  a stop bit was sampled low on the last frame.
- RX_Busy_Out  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (Reset_In=0, asynchronous): FSM goes to IDLE; all outputs 0; counters cleared; synchroniser flops set to 1; idle-armed flag cleared.
- Input sync: UART_RX passes through a 2-FF synchroniser; all logic uses the synchronised value.
- Tick generator: divisor = (SYS_CLOCK + 8*baud) / (16*baud), integer division. At 100 MHz this gives 1302, 651, 326, 163, 109, 54.
  - Tick counter restarts at start-edge detection.
  - Mode changes take effect at the next start edge only.
- Config latch: data bits, parity enable/type and stop bits are latched at start-edge detection. Input changes mid-frame are ignored.
- Arming: after reset, start detection is enabled only after the synchronised line has been seen high for at least one clock. A line held low through reset release produces no frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: armed and synchronised RX falls 1→0 → START; RX_Busy_Out=1.
  - START: at tick 7, RX=0 → DATA with sample counter reset to 0. RX=1 at tick 7 → false start, return to IDLE, no valid pulse.
  - DATA: sample every 16 ticks after the start mid-point, LSB first, into bit index n. After the last configured bit → PARITY if enabled, otherwise STOP1.
  - PARITY: sample one bit. Error when the XOR of the data bits and the parity bit is 1 (even mode) or 0 (odd mode).
  - STOP1: sample; 0 sets the framing flag. Next → STOP2 if two stop bits configured, otherwise finish.
  - STOP2: sample; 0 sets the framing flag; finish.
  - Finish: on the clock after the final stop-bit mid-sample:
    - Data_Out, Parity_Error_Out and Framing_Error_Out update.
    - Data_Valid_Out pulses for exactly 1 cycle.
    - FSM → IDLE; RX_Busy_Out=0.
- Error reporting: a framing error still delivers the data word. The error flags hold until the next Data_Valid_Out; they are not sticky across frames.
- Line timing: IDLE may detect a new start edge on the cycle after finish, so back-to-back frames with no idle gap must be received.
- Line stuck low after a framing error: no new start is detected until RX has been seen high again (re-arm rule).
- Data_Out holds its value between frames; a false start does not change it.

Test Plan:
- 115200 (divisor 54, bit = 864 clk), 8N1, send 0xA5 → Data_Out=0x0A5, one Data_Valid_Out pulse about 9.5 bit times after the start edge, both error flags 0.
- 9600, 9 data bits, even parity, 1 stop, send 0x1B3 (six ones, parity bit 0) → Data_Out=0x1B3, Parity_Error_Out=0. Resend with parity bit 1 → Data_Out=0x1B3, Parity_Error_Out=1.
- 4800, 5 data bits, odd parity, 2 stop bits, send 0x15 with the second stop bit driven 0 → Data_Out=0x015, Framing_Error_Out=1, Parity_Error_Out=0.
- 57600, 8N1, low glitch of 4 ticks (436 clk) on an idle line → no Data_Valid_Out; RX_Busy_Out pulses then returns to 0; Data_Out unchanged. Then send 0x3C → 0x03C received.
- 38400, 8N1, send 0xFF and 0x00 back-to-back with zero idle gap → two valid pulses, values 0x0FF then 0x000, no errors.
- Assert Reset_In=0 mid-DATA and release with RX held low → all outputs 0, no frame until RX goes high. Next frame 0x5A at 19200 8N1 → received correctly.
